// File: rtl/guess_entry.sv
// Keypad front end for the 1A2B game: collects three digits, validates the entry on ENTER,
// and publishes an accepted guess with a one-cycle ready pulse followed by a key lockout.
module guess_entry #(
    parameter logic [3:0] NUM_MAX   = 4'd9,
    parameter logic [3:0] KEY_CLR   = 4'hA,
    parameter logic [3:0] KEY_ENTER = 4'hB,
    parameter logic [3:0] KEY_BS    = 4'hC,
    parameter logic [3:0] HOLD_CYC  = 4'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] oNum1,
    output logic [3:0] oNum2,
    output logic [3:0] oNum3,
    output logic       oNumRdy,
    output logic       oErr,
    output logic [1:0] oCnt,
    output logic [3:0] oCur1,
    output logic [3:0] oCur2,
    output logic [3:0] oCur3,
    output logic [3:0] oTries
);

    typedef enum logic [0:0] {StEntry, StHold} state_e;

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;

    logic [1:0] cnt_q, cnt_d;
    logic [3:0] cur1_q, cur1_d, cur2_q, cur2_d, cur3_q, cur3_d;
    logic [3:0] num1_q, num1_d, num2_q, num2_d, num3_q, num3_d;
    logic       rdy_q, rdy_d, err_q, err_d;
    logic [3:0] tries_q, tries_d;

    logic key_act, is_digit, is_enter, distinct, accept, reject;

    assign key_act  = key_valid && (state_q == StEntry);
    assign is_digit = key_code <= NUM_MAX;
    assign is_enter = key_act && (key_code == KEY_ENTER);
    assign distinct = (cur1_q != cur2_q) && (cur1_q != cur3_q) && (cur2_q != cur3_q);
    assign accept   = is_enter && (cnt_q == 2'd3) && distinct;
    assign reject   = is_enter && !accept;

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEntry;
            hold_q  <= 4'd0;
            cnt_q   <= 2'd0;
            cur1_q  <= 4'd0;
            cur2_q  <= 4'd0;
            cur3_q  <= 4'd0;
            num1_q  <= 4'd0;
            num2_q  <= 4'd0;
            num3_q  <= 4'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            tries_q <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            cur1_q  <= cur1_d;
            cur2_q  <= cur2_d;
            cur3_q  <= cur3_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            num3_q  <= num3_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            tries_q <= tries_d;
        end
    end

    // Next-state: HOLD lasts exactly HOLD_CYC cycles after the accepting edge
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StEntry: begin
                if (accept) begin
                    state_d = StHold;
                    hold_d  = HOLD_CYC;
                end
            end
            StHold: begin
                hold_d = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    state_d = StEntry;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    // Entry buffer, published guess and status pulses
    always_comb begin
        cnt_d   = cnt_q;
        cur1_d  = cur1_q;
        cur2_d  = cur2_q;
        cur3_d  = cur3_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        num3_d  = num3_q;
        rdy_d   = 1'b0;
        err_d   = reject;
        tries_d = tries_q;
        if (accept) begin
            num1_d = cur1_q;
            num2_d = cur2_q;
            num3_d = cur3_q;
            rdy_d  = 1'b1;
            cnt_d  = 2'd0;
            cur1_d = 4'd0;
            cur2_d = 4'd0;
            cur3_d = 4'd0;
            if (tries_q != 4'hF) begin
                tries_d = tries_q + 4'd1;
            end
        end else if (key_act && is_digit) begin
            if (cnt_q != 2'd3) begin
                case (cnt_q)
                    2'd0:    cur1_d = key_code;
                    2'd1:    cur2_d = key_code;
                    default: cur3_d = key_code;
                endcase
                cnt_d = cnt_q + 2'd1;
            end
        end else if (key_act && (key_code == KEY_BS)) begin
            if (cnt_q != 2'd0) begin
                case (cnt_q)
                    2'd1:    cur1_d = 4'd0;
                    2'd2:    cur2_d = 4'd0;
                    default: cur3_d = 4'd0;
                endcase
                cnt_d = cnt_q - 2'd1;
            end
        end else if (key_act && (key_code == KEY_CLR)) begin
            cnt_d  = 2'd0;
            cur1_d = 4'd0;
            cur2_d = 4'd0;
            cur3_d = 4'd0;
        end
    end

    // Outputs come straight from registers so pulses are glitch-free
    always_comb begin
        oNum1   = num1_q;
        oNum2   = num2_q;
        oNum3   = num3_q;
        oNumRdy = rdy_q;
        oErr    = err_q;
        oCnt    = cnt_q;
        oCur1   = cur1_q;
        oCur2   = cur2_q;
        oCur3   = cur3_q;
        oTries  = tries_q;
    end

endmodule
